// File: rtl/syn_gpu_mul_pipe.sv
// Fully pipelined mulberry-bus multiplier (UMUL / SMUL / rounded UMUL_Q) with a
// credit-protected show-ahead response FIFO and a saturating drop counter.
module syn_gpu_mul_pipe #(
    parameter int unsigned P_DATA_W     = 16,
    parameter int unsigned P_LAT        = 4,
    parameter int unsigned P_FIFO_DEPTH = 8,
    parameter int unsigned P_FRAC_W     = 8,
    parameter int unsigned P_MID_W      = 4
) (
    input  logic                      clk_ir,
    input  logic                      rst_sync,
    input  logic [P_MID_W-1:0]        mul_req_mid,
    input  logic [1:0]                mul_req_op,
    input  logic [2*P_DATA_W-1:0]     mul_req_data,
    output logic                      mul_busy,
    output logic [P_MID_W-1:0]        mul_rsp_mid,
    output logic [2*P_DATA_W-1:0]     mul_rsp_data,
    output logic                      mul_rsp_err,
    input  logic                      mul_rsp_ready,
    output logic [7:0]                mul_drop_cnt
);

    localparam int unsigned W     = P_DATA_W;
    localparam int unsigned RES_W = 2 * P_DATA_W;
    localparam int unsigned PTR_W = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(P_FIFO_DEPTH + 1);

    localparam logic [P_MID_W-1:0] MID_IDLE = '0;
    localparam logic [1:0] OP_UMUL  = 2'b00;
    localparam logic [1:0] OP_SMUL  = 2'b01;
    localparam logic [1:0] OP_UMULQ = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Result for one operand pair; the rounding add needs one extra bit of headroom.
    function automatic logic [RES_W-1:0] mul_calc(input logic [1:0] op,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [RES_W-1:0] prod_u;
        logic [RES_W-1:0] prod_s;
        logic [RES_W:0]   prod_q;
        prod_u = RES_W'(a) * RES_W'(b);
        prod_s = RES_W'($signed(a)) * RES_W'($signed(b));
        prod_q = ((RES_W+1)'(prod_u) + ((RES_W+1)'(1) << (P_FRAC_W - 1))) >> P_FRAC_W;
        case (op)
            OP_UMUL:  mul_calc = prod_u;
            OP_SMUL:  mul_calc = prod_s;
            OP_UMULQ: mul_calc = RES_W'(prod_q);
            default:  mul_calc = '0;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(P_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic               accept;
    logic               drop;
    logic               pop;
    logic               wr_v;
    logic [P_MID_W-1:0] wr_mid;
    logic [RES_W-1:0]   wr_data;
    logic               wr_err;

    // Multiplier pipeline: P_LAT register levels from request to FIFO head.
    generate
        if (P_LAT == 1) begin : g_lat1
            always_comb begin
                wr_v    = accept;
                wr_mid  = mul_req_mid;
                wr_data = mul_calc(mul_req_op, mul_req_data[RES_W-1:W], mul_req_data[W-1:0]);
                wr_err  = (mul_req_op == OP_RSVD);
            end
        end else begin : g_latn
            logic               s0_v;
            logic [P_MID_W-1:0] s0_mid;
            logic [1:0]         s0_op;
            logic [W-1:0]       s0_a;
            logic [W-1:0]       s0_b;
            logic [RES_W-1:0]   s0_res;
            logic               s0_err;

            always_ff @(posedge clk_ir) begin
                if (rst_sync) begin
                    s0_v   <= 1'b0;
                    s0_mid <= MID_IDLE;
                    s0_op  <= OP_UMUL;
                    s0_a   <= '0;
                    s0_b   <= '0;
                end else begin
                    s0_v <= accept;
                    if (accept) begin
                        s0_mid <= mul_req_mid;
                        s0_op  <= mul_req_op;
                        s0_a   <= mul_req_data[RES_W-1:W];
                        s0_b   <= mul_req_data[W-1:0];
                    end
                end
            end

            assign s0_res = mul_calc(s0_op, s0_a, s0_b);
            assign s0_err = (s0_op == OP_RSVD);

            if (P_LAT == 2) begin : g_direct
                always_comb begin
                    wr_v    = s0_v;
                    wr_mid  = s0_mid;
                    wr_data = s0_res;
                    wr_err  = s0_err;
                end
            end else begin : g_chain
                localparam int unsigned NR = P_LAT - 2;
                logic               p_v    [NR];
                logic [P_MID_W-1:0] p_mid  [NR];
                logic [RES_W-1:0]   p_data [NR];
                logic               p_err  [NR];

                always_ff @(posedge clk_ir) begin
                    if (rst_sync) begin
                        for (int i = 0; i < int'(NR); i++) begin
                            p_v[i]   <= 1'b0;
                            p_mid[i] <= MID_IDLE;
                        end
                    end else begin
                        p_v[0]   <= s0_v;
                        p_mid[0] <= s0_mid;
                        for (int i = 1; i < int'(NR); i++) begin
                            p_v[i]   <= p_v[i-1];
                            p_mid[i] <= p_mid[i-1];
                        end
                    end
                end

                // Payload needs no reset: it is qualified by the valid chain.
                always_ff @(posedge clk_ir) begin
                    p_data[0] <= s0_res;
                    p_err[0]  <= s0_err;
                    for (int i = 1; i < int'(NR); i++) begin
                        p_data[i] <= p_data[i-1];
                        p_err[i]  <= p_err[i-1];
                    end
                end

                always_comb begin
                    wr_v    = p_v[NR-1];
                    wr_mid  = p_mid[NR-1];
                    wr_data = p_data[NR-1];
                    wr_err  = p_err[NR-1];
                end
            end
        end
    endgenerate

    logic [P_MID_W-1:0] mem_mid  [P_FIFO_DEPTH];
    logic [RES_W-1:0]   mem_data [P_FIFO_DEPTH];
    logic               mem_err  [P_FIFO_DEPTH];

    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_nx;
    logic [OCC_W-1:0]   fcnt, fcnt_nx;
    logic [OCC_W-1:0]   occ, occ_nx;
    logic [P_MID_W-1:0] head_mid_nx;
    logic [RES_W-1:0]   head_data_nx;
    logic               head_err_nx;

    // Credit accounting, FIFO pointer update and next show-ahead head.
    always_comb begin
        accept    = (mul_req_mid != MID_IDLE) && !mul_busy;
        drop      = (mul_req_mid != MID_IDLE) && mul_busy;
        pop       = mul_rsp_ready && (mul_rsp_mid != MID_IDLE);
        occ_nx    = occ + OCC_W'(accept) - OCC_W'(pop);
        fcnt_nx   = fcnt + OCC_W'(wr_v) - OCC_W'(pop);
        wr_ptr_nx = wr_v ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_nx = pop ? ptr_inc(rd_ptr) : rd_ptr;

        head_mid_nx  = MID_IDLE;
        head_data_nx = '0;
        head_err_nx  = 1'b0;
        if (fcnt_nx != '0) begin
            if (wr_v && (fcnt == OCC_W'(pop))) begin
                head_mid_nx  = wr_mid;
                head_data_nx = wr_data;
                head_err_nx  = wr_err;
            end else begin
                head_mid_nx  = mem_mid[rd_ptr_nx];
                head_data_nx = mem_data[rd_ptr_nx];
                head_err_nx  = mem_err[rd_ptr_nx];
            end
        end
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            occ          <= '0;
            fcnt         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mul_busy     <= 1'b0;
            mul_rsp_mid  <= MID_IDLE;
            mul_rsp_data <= '0;
            mul_rsp_err  <= 1'b0;
            mul_drop_cnt <= '0;
        end else begin
            occ          <= occ_nx;
            fcnt         <= fcnt_nx;
            wr_ptr       <= wr_ptr_nx;
            rd_ptr       <= rd_ptr_nx;
            mul_busy     <= (occ_nx == OCC_W'(P_FIFO_DEPTH));
            mul_rsp_mid  <= head_mid_nx;
            mul_rsp_data <= head_data_nx;
            mul_rsp_err  <= head_err_nx;
            if (drop && (mul_drop_cnt != 8'hFF)) begin
                mul_drop_cnt <= mul_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_ir) begin
        if (wr_v) begin
            mem_mid[wr_ptr]  <= wr_mid;
            mem_data[wr_ptr] <= wr_data;
            mem_err[wr_ptr]  <= wr_err;
        end
    end

endmodule

// File: tb/tb_syn_gpu_mul_pipe.sv
// Self-checking bench for syn_gpu_mul_pipe: directed cases plus randomized traffic
// checked against a queue-based transaction model.
module tb_syn_gpu_mul_pipe;

    localparam int W     = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int F     = 8;
    localparam int MW    = 4;

    logic          clk_ir = 1'b0;
    logic          rst_sync;
    logic [MW-1:0] mul_req_mid;
    logic [1:0]    mul_req_op;
    logic [2*W-1:0] mul_req_data;
    logic          mul_busy;
    logic [MW-1:0] mul_rsp_mid;
    logic [2*W-1:0] mul_rsp_data;
    logic          mul_rsp_err;
    logic          mul_rsp_ready;
    logic [7:0]    mul_drop_cnt;

    syn_gpu_mul_pipe #(
        .P_DATA_W(W), .P_LAT(LAT), .P_FIFO_DEPTH(DEPTH), .P_FRAC_W(F), .P_MID_W(MW)
    ) dut (
        .clk_ir(clk_ir), .rst_sync(rst_sync),
        .mul_req_mid(mul_req_mid), .mul_req_op(mul_req_op), .mul_req_data(mul_req_data),
        .mul_busy(mul_busy),
        .mul_rsp_mid(mul_rsp_mid), .mul_rsp_data(mul_rsp_data), .mul_rsp_err(mul_rsp_err),
        .mul_rsp_ready(mul_rsp_ready), .mul_drop_cnt(mul_drop_cnt)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct {
        logic [MW-1:0]  mid;
        logic [2*W-1:0] data;
        logic           err;
        int             t_vis;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   drop_m = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Arithmetic from the operation definitions using plain integers.
    function automatic logic [2*W-1:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint ua, ub, sa, sb;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= (longint'(1) << (W-1))) ? ua - (longint'(1) << W) : ua;
        sb = (ub >= (longint'(1) << (W-1))) ? ub - (longint'(1) << W) : ub;
        case (op)
            2'd0:    return (2*W)'(ua * ub);
            2'd1:    return (2*W)'(sa * sb);
            2'd2:    return (2*W)'((ua * ub + (longint'(1) << (F-1))) >> F);
            default: return '0;
        endcase
    endfunction

    task automatic compare_outputs();
        logic          vis;
        logic [MW-1:0] e_mid;
        logic [2*W-1:0] e_data;
        logic          e_err;
        vis    = (q.size() > 0) && (q[0].t_vis <= cyc);
        e_mid  = vis ? q[0].mid  : '0;
        e_data = vis ? q[0].data : '0;
        e_err  = vis ? q[0].err  : 1'b0;
        check_val("busy",     64'(mul_busy),     64'(q.size() == DEPTH));
        check_val("rsp_mid",  64'(mul_rsp_mid),  64'(e_mid));
        check_val("rsp_data", 64'(mul_rsp_data), 64'(e_data));
        check_val("rsp_err",  64'(mul_rsp_err),  64'(e_err));
        check_val("drop_cnt", 64'(mul_drop_cnt), 64'(drop_m));
    endtask

    // One clock: drive a request, advance the model, check the new outputs.
    task automatic step(input logic [MW-1:0] mid, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic rdy);
        logic vis, pop, acc;
        exp_t e;
        int   c_now;
        c_now = cyc;
        vis   = (q.size() > 0) && (q[0].t_vis <= cyc);
        pop   = rdy && vis;
        acc   = (mid != '0) && (q.size() != DEPTH);
        mul_req_mid   = mid;
        mul_req_op    = op;
        mul_req_data  = {a, b};
        mul_rsp_ready = rdy;
        @(posedge clk_ir);
        #1;
        cyc++;
        if (pop) q.delete(0);
        if (acc) begin
            e.mid   = mid;
            e.data  = ref_calc(op, a, b);
            e.err   = (op == 2'd3);
            e.t_vis = c_now + LAT;
            q.push_back(e);
        end else if ((mid != '0) && (drop_m < 255)) begin
            drop_m++;
        end
        compare_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step('0, 2'd0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        mul_req_mid   = '0;
        mul_req_op    = 2'd0;
        mul_req_data  = '0;
        mul_rsp_ready = 1'b0;
        rst_sync      = 1'b1;
        @(posedge clk_ir);
        #1;
        cyc++;
        rst_sync = 1'b0;
        q.delete();
        drop_m = 0;
        check_val("rst_busy", 64'(mul_busy),     64'd0);
        check_val("rst_mid",  64'(mul_rsp_mid),  64'd0);
        check_val("rst_data", 64'(mul_rsp_data), 64'd0);
        check_val("rst_err",  64'(mul_rsp_err),  64'd0);
        check_val("rst_drop", 64'(mul_drop_cnt), 64'd0);
    endtask

    initial begin
        rst_sync = 1'b1;
        do_reset();

        // Basic UMUL latency and pop.
        step(4'd3, 2'd0, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(3, 1'b1);
        check_val("umul_mid",  64'(mul_rsp_mid),  64'd3);
        check_val("umul_data", 64'(mul_rsp_data), 64'hFFFE0001);
        check_val("umul_err",  64'(mul_rsp_err),  64'd0);
        idle(1, 1'b1);
        check_val("umul_popped", 64'(mul_rsp_mid), 64'd0);

        // SMUL, UMUL_Q rounding, reserved op streamed back to back.
        step(4'd5, 2'd1, 16'hFFFF, 16'h0002, 1'b1);
        step(4'd6, 2'd1, 16'h8000, 16'h8000, 1'b1);
        step(4'd7, 2'd2, 16'h0180, 16'h0280, 1'b1);
        step(4'd8, 2'd2, 16'h0101, 16'h0001, 1'b1);
        check_val("smul_neg", 64'(mul_rsp_data), 64'hFFFFFFFE);
        step(4'd9, 2'd3, 16'h1234, 16'h5678, 1'b1);
        check_val("smul_min", 64'(mul_rsp_data), 64'h40000000);
        idle(1, 1'b1);
        check_val("umulq_a", 64'(mul_rsp_data), 64'h000003C0);
        idle(1, 1'b1);
        check_val("umulq_round", 64'(mul_rsp_data), 64'h00000001);
        idle(1, 1'b1);
        check_val("rsvd_mid",  64'(mul_rsp_mid),  64'd9);
        check_val("rsvd_data", 64'(mul_rsp_data), 64'd0);
        check_val("rsvd_err",  64'(mul_rsp_err),  64'd1);
        idle(2, 1'b1);

        // Back-pressure: 8 accepted, 2 dropped, then drain.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(4'(i), 2'd0, 16'($urandom), 16'($urandom), 1'b0);
            if (i == 8) check_val("bp_busy_full", 64'(mul_busy), 64'd1);
        end
        check_val("bp_drops", 64'(mul_drop_cnt), 64'd2);
        check_val("bp_head",  64'(mul_rsp_mid),  64'd1);
        idle(1, 1'b1);
        check_val("bp_busy_after_pop", 64'(mul_busy), 64'd0);
        step(4'd11, 2'd1, 16'($urandom), 16'($urandom), 1'b1);
        check_val("bp_acc_pop_busy", 64'(mul_busy), 64'd0);
        check_val("bp_acc_pop_drop", 64'(mul_drop_cnt), 64'd2);
        idle(12, 1'b1);

        // Reset while results are queued.
        step(4'd1, 2'd0, 16'h0003, 16'h0004, 1'b0);
        step(4'd2, 2'd1, 16'h0005, 16'h0006, 1'b0);
        step(4'd3, 2'd2, 16'h0700, 16'h0800, 1'b0);
        idle(4, 1'b0);
        check_val("pre_rst_head", 64'(mul_rsp_mid), 64'd1);
        do_reset();
        idle(8, 1'b1);

        // Streaming with ready held high: never busy, never drops.
        for (int i = 0; i < 100; i++) begin
            step(4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom), 1'b1);
        end
        idle(LAT + 2, 1'b1);
        check_val("stream_drops", 64'(mul_drop_cnt), 64'd0);

        // Random traffic with random ready: exercises credits, drops and wrap-around.
        for (int i = 0; i < 600; i++) begin
            logic [MW-1:0] m;
            m = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom_range(1, 15));
            step(m, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end
        idle(DEPTH + LAT + 2, 1'b1);
        check_val("final_empty", 64'(mul_rsp_mid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
